pid_sample_demux: RTL
=====================

PID_SAMPLE_DEMUX -- requirements
Module: pid_sample_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of one sample word.
REQ-002 SHALL have parameter DEPTH, default 2: entries per channel buffer; legal values 2 and 4 only.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data, input, DATA_W bits: interleaved sample word.
REQ-006 SHALL have port in_sel, input, 1 bit: destination tag; 1 selects channel 0, 0 selects channel 1, matching the team's mux select polarity.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data and in_sel are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts the word this cycle.
REQ-009 SHALL have ports out0_data and out1_data, output, DATA_W bits each: channel head words.
REQ-010 SHALL have ports out0_valid and out1_valid, output, 1 bit each: channel head word is valid.
REQ-011 SHALL have ports out0_ready and out1_ready, input, 1 bit each: downstream consumes the head word.
REQ-012 SHALL have port order_err, output, 1 bit: sticky sequence error (see Configuration).

Function
REQ-013 SHALL transfer an input word when in_valid && in_ready are both high at a clock edge.
REQ-014 SHALL transfer a channel output word when outN_valid && outN_ready are both high at a clock edge.
REQ-015 SHALL drive in_ready combinationally as the not-full flag of the channel addressed by in_sel, where full also counts a pop in the same cycle. in_ready SHALL NOT depend on in_valid.
REQ-016 SHALL write an accepted word into the tail of the addressed channel FIFO; the other channel SHALL be unaffected.
REQ-017 SHALL present a written word at outN_data with outN_valid=1 on the cycle after acceptance; latency is 1 cycle and there is no combinational in-to-out path.
REQ-018 SHALL keep outN_data and outN_valid stable while outN_valid=1 and outN_ready=0.
REQ-019 SHALL allow a simultaneous push and pop on a full channel without a stall; occupancy stays unchanged.
REQ-020 SHALL use pointers that wrap modulo DEPTH and occupancy counters of width clog2(DEPTH)+1.
REQ-021 SHALL let a stall on one channel block input only for words addressed to that channel; the other channel SHALL continue to flow.
REQ-022 SHALL treat outN_ready high while the channel is empty as having no effect.

Reset
REQ-023 SHALL, while rst_n=0, clear both FIFO pointers and counters and drive out0_valid=0, out1_valid=0 and order_err=0.
REQ-024 SHALL drive in_ready=1 while rst_n=0, because both channels are empty.
REQ-025 SHALL discard all buffered words when reset asserts mid-operation; outN_data is don't-care while outN_valid=0.
REQ-026 SHALL set the order checker state to EXPECT_CH0 on reset.

Configuration
REQ-027 SHALL define macro PID_DEMUX_ORDER_CHECK_EN to compile in the order checker.
REQ-028 With the macro defined, the checker SHALL run a two-state FSM, EXPECT_CH0 and EXPECT_CH1, that advances on each accepted word.
REQ-029 With the macro defined, an accepted word whose tag mismatches the expected channel SHALL set order_err=1 until reset and resynchronise the FSM to the opposite of the received tag.
REQ-030 Without the macro, order_err SHALL be tied to 0 and no checker logic SHALL exist.

Structure
REQ-031 SHALL place the DATA_W default, the DEPTH default and the checker state encodings (EXPECT_CH0=0, EXPECT_CH1=1) in the shared package pid_pkg.
REQ-032 SHALL implement each channel as an instance of sub-module pid_demux_fifo, a synchronous FIFO with valid/ready on both sides, instantiated twice.

Verification
REQ-033 Alternating words 0x0001(sel=1), 0x0002(sel=0), both ready=1 -> out0 shows 0x0001 and out1 shows 0x0002, each 1 cycle after acceptance; order_err=0.
REQ-034 out0_ready=0, three sel=1 words, DEPTH=2 -> in_ready drops after the 2nd word; the 3rd is accepted only after out0_ready=1; data order is preserved.
REQ-035 Channel 0 full and stalled, sel=0 words 0xAAAA and 0xBBBB -> both accepted and delivered on out1 back-to-back.
REQ-036 Full channel with a push and pop in the same cycle -> no bubble on in_ready; occupancy stays 2.
REQ-037 With the macro defined, tags 1,1 -> order_err=1 after the 2nd acceptance and stays 1; without the macro, order_err stays 0.
REQ-038 rst_n pulsed low with 2 words buffered -> outN_valid=0 immediately and in_ready=1; no stale word appears after release.

Source files
------------

// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
// pid_pkg : shared defaults and order-checker state encodings for the demux
// Rev 1.0 : initial release
// ============================================================================
package pid_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 2;

  typedef enum logic {
    EXPECT_CH0 = 1'b0,
    EXPECT_CH1 = 1'b1
  } order_state_t;

endpackage
`default_nettype wire

// File: rtl/pid_sample_demux_if.sv
`default_nettype none
// ============================================================================
// pid_sample_demux_if : valid/ready word stream used between demux and FIFOs
// Rev 1.0 : initial release
// ============================================================================
interface pid_sample_demux_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/pid_demux_fifo.sv
`default_nettype none
// ============================================================================
// pid_demux_fifo : one-clock FIFO, valid/ready on both sides, DEPTH 2 or 4
// Rev 1.0 : initial release
// ============================================================================
module pid_demux_fifo
  import pid_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pid_sample_demux_if.slave  push,
  pid_sample_demux_if.master pop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign pop.valid = !empty;
  assign pop.data  = mem[rd_ptr];
  assign do_pop    = pop.valid && pop.ready;
  // A pop frees a slot this same edge, so a full FIFO still takes a word.
  assign push.ready = !full || do_pop;
  assign do_push    = push.valid && push.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push.data;
  end

endmodule
`default_nettype wire

// File: rtl/pid_sample_demux.sv
`default_nettype none
// ============================================================================
// pid_sample_demux : splits a tagged word stream into two buffered channels
// Optional order checker compiled in with macro PID_DEMUX_ORDER_CHECK_EN
// Rev 1.0 : initial release
// ============================================================================
module pid_sample_demux
  import pid_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic [DATA_W-1:0] in_data,
  input  wire logic              in_sel,
  input  wire logic              in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out0_data,
  output logic                   out0_valid,
  input  wire logic              out0_ready,
  output logic [DATA_W-1:0]      out1_data,
  output logic                   out1_valid,
  input  wire logic              out1_ready,
  output logic                   order_err
);

  pid_sample_demux_if #(.DATA_W(DATA_W)) ch0_in  ();
  pid_sample_demux_if #(.DATA_W(DATA_W)) ch0_out ();
  pid_sample_demux_if #(.DATA_W(DATA_W)) ch1_in  ();
  pid_sample_demux_if #(.DATA_W(DATA_W)) ch1_out ();

  // in_sel=1 addresses channel 0, in_sel=0 addresses channel 1.
  assign ch0_in.data  = in_data;
  assign ch0_in.valid = in_valid && in_sel;
  assign ch1_in.data  = in_data;
  assign ch1_in.valid = in_valid && !in_sel;
  assign in_ready     = in_sel ? ch0_in.ready : ch1_in.ready;

  assign out0_data     = ch0_out.data;
  assign out0_valid    = ch0_out.valid;
  assign ch0_out.ready = out0_ready;
  assign out1_data     = ch1_out.data;
  assign out1_valid    = ch1_out.valid;
  assign ch1_out.ready = out1_ready;

  pid_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch0_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ch0_in.slave),
    .pop   (ch0_out.master)
  );

  pid_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ch1_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ch1_in.slave),
    .pop   (ch1_out.master)
  );

`ifdef PID_DEMUX_ORDER_CHECK_EN
  order_state_t state_q;
  order_state_t state_d;
  logic         err_q;
  logic         err_d;
  logic         accept;

  assign accept    = in_valid && in_ready;
  assign order_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EXPECT_CH0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next state is always the opposite of the channel just received,
  // which both advances on a match and resynchronises on a mismatch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (accept) begin
      if (in_sel != (state_q == EXPECT_CH0)) err_d = 1'b1;
      state_d = in_sel ? EXPECT_CH1 : EXPECT_CH0;
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule
`default_nettype wire
